// File: rtl/jk_chk_pkg.sv
// Shared definitions for the jk_ff on-line checker.
// State encoding, JK codes and the reference next-state function.
package jk_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(
    input logic j,
    input logic k,
    input logic dut_rst,
    input logic q
  );
    logic n;
    n = q;
    if (dut_rst) begin
      n = 1'b0;
    end else begin
      unique case ({j, k})
        JK_HOLD: n = q;
        JK_RST:  n = 1'b0;
        JK_SET:  n = 1'b1;
        JK_TGL:  n = ~q;
        default: n = q;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/jk_model.sv
// Registered JK reference flop with a parallel load path.
// Load wins over step; load is used for alignment and resync.
module jk_model
  import jk_chk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  input  logic dut_rst,
  input  logic load_en,
  input  logic load_val,
  input  logic step,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_val;
    end else if (step) begin
      q_d = jk_next(j, k, dut_rst, q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_ff_checker.sv
// On-line checker for a jk_ff: reference model, compare, counters,
// first-failure capture and JK code coverage.
module jk_ff_checker
  import jk_chk_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0,
  parameter bit RESYNC      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dut_rst,
  input  logic             j,
  input  logic             k,
  input  logic             q_obs,
  output logic             q_exp,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [1:0]       first_err_jk,
  output logic [3:0]       cov_mask,
  output logic [1:0]       state
);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] fcyc_q, fcyc_d;
  logic [1:0]       fjk_q, fjk_d;
  logic [1:0]       jk_prev_q, jk_prev_d;
  logic [3:0]       cov_q, cov_d;

  logic cmp;
  logic m_load;
  logic m_val;
  logic m_step;

  // Case inequality so an X/Z on q_obs counts as a miss.
  assign cmp = (q_obs !== q_exp);

  always_comb begin
    state_d    = state_q;
    mismatch_d = 1'b0;
    sticky_d   = sticky_q;
    err_d      = err_q;
    chk_d      = chk_q;
    fcyc_d     = fcyc_q;
    fjk_d      = fjk_q;
    jk_prev_d  = jk_prev_q;
    cov_d      = cov_q;
    m_load     = 1'b0;
    m_val      = 1'b0;
    m_step     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (en) state_d = S_ARMED;
      end
      (state_q == S_ARMED): begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (dut_rst) begin
          m_load  = 1'b1;
          state_d = S_CHECK;
        end
      end
      (state_q == S_CHECK): begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          chk_d     = sat_inc(chk_q);
          cov_d     = cov_q | (4'b0001 << {j, k});
          jk_prev_d = {j, k};
          if (cmp && RESYNC) begin
            m_load = 1'b1;
            m_val  = jk_next(j, k, dut_rst, q_obs);
          end else begin
            m_step = 1'b1;
          end
          if (cmp) begin
            mismatch_d = 1'b1;
            err_d      = sat_inc(err_q);
            if (!sticky_q) begin
              sticky_d = 1'b1;
              fcyc_d   = chk_q;
              fjk_d    = jk_prev_q;
            end
            if (STOP_ON_ERR) state_d = S_FAIL;
          end
        end
      end
      (state_q == S_FAIL): begin
        state_d = S_FAIL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_q      <= '0;
      chk_q      <= '0;
      fcyc_q     <= '0;
      fjk_q      <= 2'b00;
      jk_prev_q  <= 2'b00;
      cov_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      sticky_q   <= sticky_d;
      err_q      <= err_d;
      chk_q      <= chk_d;
      fcyc_q     <= fcyc_d;
      fjk_q      <= fjk_d;
      jk_prev_q  <= jk_prev_d;
      cov_q      <= cov_d;
    end
  end

  jk_model u_model (
    .clk      (clk),
    .rst      (rst),
    .j        (j),
    .k        (k),
    .dut_rst  (dut_rst),
    .load_en  (m_load),
    .load_val (m_val),
    .step     (m_step),
    .q        (q_exp)
  );

  assign mismatch      = mismatch_q;
  assign err_sticky    = sticky_q;
  assign err_count     = err_q;
  assign chk_count     = chk_q;
  assign first_err_cyc = fcyc_q;
  assign first_err_jk  = fjk_q;
  assign cov_mask      = cov_q;
  assign state         = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker across four parameter sets.
// q_obs is driven by hand to play the observed jk_ff.
module tb_jk_ff_checker;

  logic clk = 1'b0;
  logic rst, en, dut_rst, j, k, q_obs;

  always #5 clk = ~clk;

  logic        d_qe, d_mm, d_sk;
  logic [15:0] d_err, d_chk, d_fc;
  logic [1:0]  d_fj, d_st;
  logic [3:0]  d_cov;

  logic        s_qe, s_mm, s_sk;
  logic [15:0] s_err, s_chk, s_fc;
  logic [1:0]  s_fj, s_st;
  logic [3:0]  s_cov;

  logic        n_qe, n_mm, n_sk;
  logic [15:0] n_err, n_chk, n_fc;
  logic [1:0]  n_fj, n_st;
  logic [3:0]  n_cov;

  logic        w_qe, w_mm, w_sk;
  logic [2:0]  w_err, w_chk, w_fc;
  logic [1:0]  w_fj, w_st;
  logic [3:0]  w_cov;

  jk_ff_checker u_def (
    .clk(clk), .rst(rst), .en(en), .dut_rst(dut_rst),
    .j(j), .k(k), .q_obs(q_obs),
    .q_exp(d_qe), .mismatch(d_mm), .err_sticky(d_sk),
    .err_count(d_err), .chk_count(d_chk),
    .first_err_cyc(d_fc), .first_err_jk(d_fj),
    .cov_mask(d_cov), .state(d_st)
  );

  jk_ff_checker #(.STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .rst(rst), .en(en), .dut_rst(dut_rst),
    .j(j), .k(k), .q_obs(q_obs),
    .q_exp(s_qe), .mismatch(s_mm), .err_sticky(s_sk),
    .err_count(s_err), .chk_count(s_chk),
    .first_err_cyc(s_fc), .first_err_jk(s_fj),
    .cov_mask(s_cov), .state(s_st)
  );

  jk_ff_checker #(.RESYNC(1'b0)) u_nors (
    .clk(clk), .rst(rst), .en(en), .dut_rst(dut_rst),
    .j(j), .k(k), .q_obs(q_obs),
    .q_exp(n_qe), .mismatch(n_mm), .err_sticky(n_sk),
    .err_count(n_err), .chk_count(n_chk),
    .first_err_cyc(n_fc), .first_err_jk(n_fj),
    .cov_mask(n_cov), .state(n_st)
  );

  jk_ff_checker #(.CNT_W(3)) u_w3 (
    .clk(clk), .rst(rst), .en(en), .dut_rst(dut_rst),
    .j(j), .k(k), .q_obs(q_obs),
    .q_exp(w_qe), .mismatch(w_mm), .err_sticky(w_sk),
    .err_count(w_err), .chk_count(w_chk),
    .first_err_cyc(w_fc), .first_err_jk(w_fj),
    .cov_mask(w_cov), .state(w_st)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; en = 1'b0; dut_rst = 1'b0;
    j = 1'b0; k = 1'b0; q_obs = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic arm_align();
    en = 1'b1;
    tick();
    dut_rst = 1'b1;
    tick();
    dut_rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_rst();
    chk("rst_state", 32'(d_st), 32'd0);
    chk("rst_qexp", 32'(d_qe), 32'd0);
    chk("rst_mm", 32'(d_mm), 32'd0);
    chk("rst_sticky", 32'(d_sk), 32'd0);
    chk("rst_err", 32'(d_err), 32'd0);
    chk("rst_chk", 32'(d_chk), 32'd0);
    chk("rst_cov", 32'(d_cov), 32'd0);

    // 1: clean sweep of all JK codes
    en = 1'b1;
    tick();
    chk("t1_armed", 32'(d_st), 32'd1);
    dut_rst = 1'b1;
    tick();
    chk("t1_check", 32'(d_st), 32'd2);
    chk("t1_chk0", 32'(d_chk), 32'd0);
    dut_rst = 1'b0;
    j = 0; k = 0; tick(); q_obs = 1'b0;
    j = 0; k = 1; tick(); q_obs = 1'b0;
    j = 1; k = 0; tick(); q_obs = 1'b1;
    chk("t1_qexp_set", 32'(d_qe), 32'd1);
    j = 1; k = 1; tick(); q_obs = 1'b0;
    j = 0; k = 0; tick();
    chk("t1_err", 32'(d_err), 32'd0);
    chk("t1_chk", 32'(d_chk), 32'd5);
    chk("t1_cov", 32'(d_cov), 32'hf);
    chk("t1_qexp", 32'(d_qe), 32'd0);
    chk("t1_mm", 32'(d_mm), 32'd0);
    en = 1'b0;
    tick();
    chk("t1_idle", 32'(d_st), 32'd0);
    chk("t1_chk_hold", 32'(d_chk), 32'd5);

    // 2: one injected miss after JK=01, resync recovers
    do_rst();
    arm_align();
    j = 0; k = 0; tick(); q_obs = 1'b0;
    j = 0; k = 1; tick(); q_obs = 1'b1;
    j = 1; k = 0; tick(); q_obs = 1'b1;
    chk("t2_mm", 32'(d_mm), 32'd1);
    chk("t2_err", 32'(d_err), 32'd1);
    chk("t2_sticky", 32'(d_sk), 32'd1);
    chk("t2_fjk", 32'(d_fj), 32'd1);
    chk("t2_fcyc", 32'(d_fc), 32'd2);
    chk("t2_qexp", 32'(d_qe), 32'd1);
    j = 1; k = 1; tick(); q_obs = 1'b0;
    chk("t2_pulse", 32'(d_mm), 32'd0);
    j = 0; k = 0; tick();
    chk("t2_err_end", 32'(d_err), 32'd1);
    chk("t2_chk_end", 32'(d_chk), 32'd5);
    chk("t2_fcyc_keep", 32'(d_fc), 32'd2);

    // 3: stop on first error
    do_rst();
    arm_align();
    j = 0; k = 0; tick(); q_obs = 1'b1;
    tick();
    chk("t3_fail", 32'(s_st), 32'd3);
    chk("t3_mm_entry", 32'(s_mm), 32'd1);
    chk("t3_chk", 32'(s_chk), 32'd2);
    j = 1; k = 1; q_obs = 1'b0; dut_rst = 1'b1; en = 1'b0;
    tick();
    j = 1; k = 0; q_obs = 1'b1; dut_rst = 1'b0; en = 1'b1;
    tick();
    tick();
    chk("t3_stay", 32'(s_st), 32'd3);
    chk("t3_mm0", 32'(s_mm), 32'd0);
    chk("t3_chk_frz", 32'(s_chk), 32'd2);
    chk("t3_err_frz", 32'(s_err), 32'd1);
    chk("t3_qexp_frz", 32'(s_qe), 32'd1);
    chk("t3_cov_frz", 32'(s_cov), 32'h1);
    do_rst();
    chk("t3_rst_st", 32'(s_st), 32'd0);
    chk("t3_rst_chk", 32'(s_chk), 32'd0);
    chk("t3_rst_err", 32'(s_err), 32'd0);
    chk("t3_rst_sk", 32'(s_sk), 32'd0);

    // 4a: toggle 20 cycles with a correct DUT
    arm_align();
    j = 1; k = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("t4_tgl%0d", i), 32'(d_qe), 32'(i % 2 == 0));
      q_obs = (i % 2 == 0);
    end
    chk("t4_err0", 32'(d_err), 32'd0);
    chk("t4_chk20", 32'(d_chk), 32'd20);

    // 4b: no resync, one flip gives persistent divergence
    do_rst();
    arm_align();
    j = 1; k = 1;
    for (int i = 0; i < 20; i++) begin
      q_obs = (i % 2 == 0);
      tick();
    end
    chk("t4_nors_err", 32'(n_err), 32'd20);
    chk("t4_nors_chk", 32'(n_chk), 32'd20);
    chk("t4_nors_fc", 32'(n_fc), 32'd0);
    chk("t4_nors_qe", 32'(n_qe), 32'd0);

    // 5: armed without dut_rst never checks
    do_rst();
    en = 1'b1;
    repeat (6) tick();
    chk("t5_armed", 32'(d_st), 32'd1);
    chk("t5_chk0", 32'(d_chk), 32'd0);
    en = 1'b0;
    tick();
    chk("t5_idle", 32'(d_st), 32'd0);

    // 6: saturation at CNT_W=3
    do_rst();
    arm_align();
    j = 0; k = 1; q_obs = 1'b1;
    repeat (10) tick();
    chk("t6_err_sat", 32'(w_err), 32'd7);
    chk("t6_chk_sat", 32'(w_chk), 32'd7);
    chk("t6_mm", 32'(w_mm), 32'd1);
    chk("t6_fc", 32'(w_fc), 32'd0);

    // 7: en drop with dut_rst, re-arm, dut_rst in CHECK, rst mid-CHECK
    do_rst();
    arm_align();
    j = 1; k = 0; tick(); q_obs = 1'b1;
    chk("t7_qe1", 32'(d_qe), 32'd1);
    en = 1'b0; dut_rst = 1'b1;
    tick();
    chk("t7_idle", 32'(d_st), 32'd0);
    chk("t7_qe_hold", 32'(d_qe), 32'd1);
    chk("t7_chk_hold", 32'(d_chk), 32'd1);
    en = 1'b1; dut_rst = 1'b0;
    tick();
    chk("t7_rearm", 32'(d_st), 32'd1);
    dut_rst = 1'b1;
    tick();
    q_obs = 1'b0;
    chk("t7_align", 32'(d_qe), 32'd0);
    tick();
    chk("t7_rst_cmp", 32'(d_chk), 32'd2);
    chk("t7_rst_q", 32'(d_qe), 32'd0);
    chk("t7_rst_mm", 32'(d_mm), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_clr_st", 32'(d_st), 32'd0);
    chk("t7_clr_chk", 32'(d_chk), 32'd0);
    chk("t7_clr_cov", 32'(d_cov), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_ff_checker.md
Name: jk_ff_checker

Overview:
- Synthesizable on-line checker for the other end of the jk_ff interface: it observes the J, K and reset stimulus driven into a jk_ff instance, together with that instance's Q.
- Runs an independent reference model, compares every clock, and counts mismatches and checks.
- Captures first-failure context and records which JK codes have been exercised.
- Used in self-checking benches and as an on-chip BIST monitor next to jk_ff.

Parameters:
CNT_W, 16, width of all counters and the cycle-stamp register
STOP_ON_ERR, 0, 1 = enter FAIL on first mismatch and stop checking
RESYNC, 1, 1 = after a mismatch, the model reloads from the observed Q

Ports:
clk  input  1  checker clock, same clock as the observed jk_ff
rst  input  1  checker reset, synchronous, active-high
en  input  1  check enable
dut_rst  input  1  reset applied to the observed jk_ff
j  input  1  J applied to the observed jk_ff
k  input  1  K applied to the observed jk_ff
q_obs  input  1  Q of the observed jk_ff
q_exp  output  1  model Q
mismatch  output  1  one-cycle pulse per detected mismatch
err_sticky  output  1  set on first mismatch, cleared only by rst
err_count  output  CNT_W  mismatches, saturating
chk_count  output  CNT_W  comparisons performed, saturating
first_err_cyc  output  CNT_W  chk_count value at first mismatch
first_err_jk  output  2  {j,k} of the cycle that produced the first failing Q
cov_mask  output  4  bit n set once JK code n ({j,k}) is applied in CHECK
state  output  2  FSM state, for debug

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, q_exp=0, mismatch=0, err_sticky=0. All counters, first_err_*, and cov_mask are 0. rst has priority over every other input.
- Model next-state (jk_next):
  - dut_rst=1 -> 0
  - JK=00 -> hold
  - JK=01 -> 0
  - JK=10 -> 1
  - JK=11 -> ~q
- FSM states: IDLE=0, ARMED=1, CHECK=2, FAIL=3.
  - IDLE: no compare, no counting. en=1 -> ARMED.
  - ARMED: waits for dut_rst=1 to align the model with the DUT. At that edge, q_exp<=0 and the FSM goes to CHECK. en=0 -> IDLE.
  - CHECK: compares at every posedge (see Compare below). en=0 -> IDLE; counters and capture registers hold. A mismatch with STOP_ON_ERR=1 -> FAIL.
  - FAIL: all outputs frozen except mismatch, which is 0. Leaves FAIL only on rst.
- Compare (CHECK only), per posedge:
  - cmp = (q_obs != q_exp), evaluated with pre-edge values.
  - chk_count increments, saturating at all-ones.
  - cov_mask[{j,k}] <= 1.
  - q_exp <= jk_next(j, k, dut_rst, base), where base = q_obs if (cmp && RESYNC) else q_exp.
- Mismatch, registered:
  - mismatch <= cmp; err_count increments, saturating.
  - If err_sticky was 0: err_sticky<=1, first_err_cyc<=chk_count (pre-increment value), first_err_jk<={j,k} as registered on the previous CHECK edge.
  - A one-entry jk_prev register supplies that value; it updates every CHECK edge.
- Latency:
  - The DUT output after edge N is compared at edge N+1.
  - mismatch is high during the cycle after edge N+1.
- Boundary conditions:
  - Saturation: err_count and chk_count stop at all-ones and never wrap.
  - dut_rst in CHECK: compare still runs; the model goes to 0.
  - en drop and dut_rst at the same edge in CHECK: go IDLE; the model does not update.
  - Re-enable from IDLE: always passes through ARMED again, so re-alignment is required.
  - X or Z on q_obs: treated as mismatch (case-inequality in simulation).
  - rst mid-CHECK: full clear at that edge.

Decomposition:
- Shared package jk_chk_pkg holds:
  - state encoding constants S_IDLE/S_ARMED/S_CHECK/S_FAIL, 2 bits
  - JK code constants JK_HOLD=00, JK_RST=01, JK_SET=10, JK_TGL=11
  - the jk_next function
- One sub-module, jk_model: registered reference Q with inputs j, k, dut_rst, load_en, load_val, step. Reused by future T/D/SR checkers.

Test Plan:
1. 10 ns clock. en=1, dut_rst=1 for 1 cycle, then JK=00,01,10,11 for one cycle each with a correct jk_ff -> after final compare: err_count=0, chk_count=5, cov_mask=4'b1111, q_exp=0.
2. Same sequence with q_obs forced to 1 during the JK=01 result cycle -> one mismatch pulse; err_count=1, err_sticky=1, first_err_jk=2'b01, first_err_cyc=2. The following compares match because RESYNC=1.
3. STOP_ON_ERR=1, single injected mismatch -> state=FAIL. chk_count frozen; further stimulus changes no output; rst returns IDLE with all zeros.
4. JK=11 held 20 cycles with correct DUT -> q_exp alternates 1,0,1,... and no mismatch. With RESYNC=0 and one injected error -> err_count=20 (persistent divergence).
5. en=1 without dut_rst for 5 cycles -> state stays ARMED, chk_count=0. Then en=0 -> IDLE.
6. CNT_W=3, 10 mismatches -> err_count saturates at 7; chk_count saturates at 7.
